// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, $0 hardwired to zero.
module mips_register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  // r0 has no storage, so the array starts at index 1.
  logic [31:0] regs [1:31];
  logic [31:1] write_dec;

  // One-hot write decode gated by reg_write; address 0 has no decode line,
  // which is what silently discards writes to $zero.
  always_comb begin
    write_dec = '0;
    for (int i = 1; i < 32; i++) begin
      write_dec[i] = reg_write && (write_reg == 5'(i));
    end
  end

  for (genvar g = 1; g < 32; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        regs[g] <= '0;
      end else if (write_dec[g]) begin
        regs[g] <= write_data;
      end
    end
  end

  // Read muxes: no bypass, so a same-cycle write shows up only after the edge.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (read_reg1 == 5'(i)) read_data1 = regs[i];
      if (read_reg2 == 5'(i)) read_data2 = regs[i];
    end
  end

endmodule
